uart_rx_deframer: RTL

//  Receives asynchronous 8-bit UART frames from the USB_UART_RX pin and presents each byte
//  to the command decoder through a Receive/Received req-ack handshake.

---
 rtl/uart_rx_deframer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Recovers 8-bit UART frames (start, 8 data LSB first, parity, stop) from an
// asynchronous line and hands each good byte to the consumer over a
// Receive/Received request-acknowledge handshake. A byte with bad parity is
// still delivered, flagged by parityErr; a frame with a bad stop bit is
// dropped and the line must return high before the next start is hunted.
module uart_rx_deframer #(
  parameter int CLK_FREQ   = 32'd100_000_000,
  parameter int BAUD       = 32'd19_200,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  output logic       Receive,
  input  logic       Received,
  output logic [7:0] Dout,
  output logic       parityErr
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 32'sd2;
  localparam int TMR_W    = $clog2(BIT_CNT);

  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_CNT - 32'sd1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_CNT - 32'sd1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(32'sd1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};

  // The mid-bit sampling scheme needs at least a few clocks per bit.
  if (BIT_CNT < 32'sd4) begin : g_bit_cnt_check
    $error("uart_rx_deframer: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_ACK    = 3'd6,
    ST_ACKLOW = 3'd7
  } state_t;

  // Parity error for a received byte plus its parity bit.
  function automatic logic parity_err_f(input logic [7:0] data, input logic pbit);
    logic p;
    p = ^{data, pbit};
    return PARITY_ODD ? ~p : p;
  endfunction

  logic [1:0]       sync_r;
  logic             sin_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [TMR_W-1:0] tmr_r;
  logic [2:0]       idx_r;
  logic [7:0]       shreg_r;
  logic             pbit_r;
  logic             bit_done_s;
  logic             half_done_s;
  logic             tmr_run_s;
  logic             shift_en_s;
  logic             pbit_en_s;
  logic             load_en_s;
  logic             ack_clr_s;

  assign sin_s       = sync_r[1];
  assign bit_done_s  = (tmr_r == BIT_LAST);
  assign half_done_s = (tmr_r == HALF_LAST);

  // Two-flop synchroniser for the asynchronous line, preset to the idle level.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], Sin};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    tmr_run_s   = 1'b0;
    shift_en_s  = 1'b0;
    pbit_en_s   = 1'b0;
    load_en_s   = 1'b0;
    ack_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!sin_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        tmr_run_s = 1'b1;
        if (half_done_s) begin
          // A line already back high at mid-start is treated as a glitch.
          state_nxt_s = sin_s ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        tmr_run_s = 1'b1;
        if (bit_done_s) begin
          shift_en_s  = 1'b1;
          state_nxt_s = (idx_r == 3'd7) ? ST_PARITY : ST_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        tmr_run_s = 1'b1;
        if (bit_done_s) begin
          pbit_en_s   = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        tmr_run_s = 1'b1;
        if (bit_done_s) begin
          load_en_s   = sin_s;
          state_nxt_s = sin_s ? ST_ACK : ST_BREAK;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (sin_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      ST_ACK: begin
        if (Received) begin
          ack_clr_s   = 1'b1;
          state_nxt_s = ST_ACKLOW;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_ACKLOW: begin
        if (!Received) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACKLOW;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bit timer restarts on every state change and after each data bit; the
  // bit index is held at zero outside DATA so every frame starts at bit 0.
  always_ff @(posedge clk) begin
    if (Reset) begin
      tmr_r <= TMR_ZERO;
      idx_r <= 3'd0;
    end else begin
      if ((state_nxt_s != state_r) || shift_en_s) begin
        tmr_r <= TMR_ZERO;
      end else if (tmr_run_s) begin
        tmr_r <= tmr_r + TMR_ONE;
      end else begin
        tmr_r <= tmr_r;
      end
      if (state_r != ST_DATA) begin
        idx_r <= 3'd0;
      end else if (shift_en_s) begin
        idx_r <= idx_r + 3'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Data shift register and captured parity bit.
  always_ff @(posedge clk) begin
    if (Reset) begin
      shreg_r <= 8'h00;
      pbit_r  <= 1'b0;
    end else begin
      if (shift_en_s) begin
        shreg_r[idx_r] <= sin_s;
      end else begin
        shreg_r <= shreg_r;
      end
      if (pbit_en_s) begin
        pbit_r <= sin_s;
      end else begin
        pbit_r <= pbit_r;
      end
    end
  end

  // Registered handshake and byte outputs; byte and flag hold until the next good frame.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Receive   <= 1'b0;
      Dout      <= 8'h00;
      parityErr <= 1'b0;
    end else if (load_en_s) begin
      Receive   <= 1'b1;
      Dout      <= shreg_r;
      parityErr <= parity_err_f(shreg_r, pbit_r);
    end else if (ack_clr_s) begin
      Receive   <= 1'b0;
    end else begin
      Receive   <= Receive;
    end
  end

endmodule
